// File: rtl/cache_miss_handler_if.sv
// Handshake bundle between the L1 hit path, the miss handler and physical memory.
// master drives the access/memory-response side, slave is the miss handler.
interface cache_miss_handler_if #(
  parameter int IDX_W = 3
);
  logic             req;
  logic [IDX_W-1:0] set_index;
  logic             hit;
  logic [3:0]       hit_way;
  logic [3:0]       valid;
  logic [3:0]       dirty;
  logic             pmem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic             wb_addr_sel;
  logic [3:0]       way_load;
  logic [3:0]       victim_way;
  logic             busy;

  modport master (
    output req, set_index, hit, hit_way, valid, dirty, pmem_resp,
    input  pmem_read, pmem_write, wb_addr_sel, way_load, victim_way, busy
  );

  modport slave (
    input  req, set_index, hit, hit_way, valid, dirty, pmem_resp,
    output pmem_read, pmem_write, wb_addr_sel, way_load, victim_way, busy
  );
endinterface

// File: rtl/cache_miss_handler.sv
// 4-way L1 miss handler: per-set tree PLRU, victim choice, optional dirty
// writeback followed by a line fill, and the one-hot way load strobe.
//
// state     | meaning
// IDLE      | accepting accesses; hits touch PLRU, a miss latches the victim
// WRITEBACK | writing the dirty victim line back, waiting for pmem_resp
// FILL      | reading the new line, way_load pulses on pmem_resp
module cache_miss_handler #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_miss_handler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       plru_q [NUM_SETS];
  logic [IDX_W-1:0] set_q;
  logic [3:0]       victim_q;
  logic             busy_q;
  logic             pmem_read_q;
  logic             pmem_write_q;
  logic             wb_addr_sel_q;

  logic [2:0]       tree;
  logic [3:0]       victim_sel;
  logic [3:0]       hit_lowest;

  // Point the tree away from the touched way; bits on the other side stay put.
  function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [3:0] w);
    logic [2:0] r;
    r = t;
    case (w)
      4'b0001: r = {t[2], 2'b11};
      4'b0010: r = {t[2], 2'b01};
      4'b0100: r = {1'b1, t[1], 1'b0};
      4'b1000: r = {1'b0, t[1], 1'b0};
      default: r = t;
    endcase
    return r;
  endfunction

  assign tree       = plru_q[bus.set_index];
  assign hit_lowest = bus.hit_way & (~bus.hit_way + 4'd1);

  always_comb begin
    victim_sel = 4'b0001;
    if (!bus.valid[0])      victim_sel = 4'b0001;
    else if (!bus.valid[1]) victim_sel = 4'b0010;
    else if (!bus.valid[2]) victim_sel = 4'b0100;
    else if (!bus.valid[3]) victim_sel = 4'b1000;
    else if (!tree[0])      victim_sel = tree[1] ? 4'b0010 : 4'b0001;
    else                    victim_sel = tree[2] ? 4'b1000 : 4'b0100;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      set_q         <= '0;
      victim_q      <= '0;
      busy_q        <= 1'b0;
      pmem_read_q   <= 1'b0;
      pmem_write_q  <= 1'b0;
      wb_addr_sel_q <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) plru_q[i] <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req && bus.hit) begin
            plru_q[bus.set_index] <= plru_touch(tree, hit_lowest);
          end else if (bus.req) begin
            victim_q <= victim_sel;
            set_q    <= bus.set_index;
            busy_q   <= 1'b1;
            if (|(victim_sel & bus.valid & bus.dirty)) begin
              state         <= WRITEBACK;
              pmem_write_q  <= 1'b1;
              wb_addr_sel_q <= 1'b1;
            end else begin
              state         <= FILL;
              pmem_read_q   <= 1'b1;
              wb_addr_sel_q <= 1'b0;
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            state         <= FILL;
            pmem_write_q  <= 1'b0;
            pmem_read_q   <= 1'b1;
            wb_addr_sel_q <= 1'b0;
          end
        end
        FILL: begin
          if (bus.pmem_resp) begin
            state         <= IDLE;
            pmem_read_q   <= 1'b0;
            busy_q        <= 1'b0;
            plru_q[set_q] <= plru_touch(plru_q[set_q], victim_q);
          end
        end
        default: begin
          state         <= IDLE;
          busy_q        <= 1'b0;
          pmem_read_q   <= 1'b0;
          pmem_write_q  <= 1'b0;
          wb_addr_sel_q <= 1'b0;
        end
      endcase
    end
  end

  // The load strobe rides on the fill response itself so data lands that cycle.
  assign bus.way_load    = (state == FILL && bus.pmem_resp) ? victim_q : 4'b0000;
  assign bus.victim_way  = victim_q;
  assign bus.busy        = busy_q;
  assign bus.pmem_read   = pmem_read_q;
  assign bus.pmem_write  = pmem_write_q;
  assign bus.wb_addr_sel = wb_addr_sel_q;

endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Miss-side counterpart of the 4-way tag-compare hit path in the L1 cache.
- Takes the hit result (hit flag plus one-hot way) and the valid/dirty bits of the indexed set.
- Maintains per-set tree pseudo-LRU state and chooses a victim way on a miss.
- Sequences an optional dirty writeback, then a line fill, over the physical-memory handshake, and issues a one-hot way load strobe when the line returns.

Parameters:
- NUM_SETS, 8, number of sets; each set holds one 3-bit PLRU tree.
- IDX_W, 3, set index width; equals log2(NUM_SETS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  CPU access to the cache is valid this cycle.
- set_index  in  IDX_W  set addressed by the current access.
- hit  in  1  tag match in some valid way.
- hit_way  in  4  one-hot hit way, bit n = way n.
- valid  in  4  valid bits of the indexed set, bit n = way n.
- dirty  in  4  dirty bits of the indexed set, bit n = way n.
- pmem_resp  in  1  physical memory has completed the current read or write.
- pmem_read  out  1  fill request to physical memory.
- pmem_write  out  1  writeback request to physical memory.
- wb_addr_sel  out  1  1 = memory address is formed from the victim's stored tag (writeback); 0 = from the CPU tag (fill).
- way_load  out  4  one-hot strobe loading data, tag and valid=1, dirty=0 into the victim way.
- victim_way  out  4  one-hot victim latched at the start of the miss.
- busy  out  1  a miss is in progress; the CPU stalls while this is high.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all PLRU trees=3'b000; victim_way=0. Every output is 0 in the cycle after rst is sampled high.
- Reset mid-miss aborts the miss: state goes to IDLE, pmem_read and pmem_write drop, and no way_load is issued.
- PLRU encoding per set, bits {b2,b1,b0}:
  - b0=0 → victim in {0,1}; b0=1 → victim in {2,3}.
  - b1 chooses within {0,1}: 0→way0, 1→way1.
  - b2 chooses within {2,3}: 0→way2, 1→way3.
- PLRU touch of way w (points the tree away from w; unlisted bits unchanged):
  - w0: b0=1, b1=1.
  - w1: b0=1, b1=0.
  - w2: b0=0, b2=1.
  - w3: b0=0, b2=0.
- Victim selection, combinational in IDLE:
  - If any valid bit is 0, pick the lowest-index invalid way.
  - Otherwise pick the way given by the PLRU tree.
- States:
  - IDLE:
    - req & hit: touch the PLRU of set_index with hit_way. If hit_way has several bits set, use the lowest set bit. If hit_way is 0, no update.
    - req & !hit: latch victim_way and set_index, and assert busy from the next cycle. Go to WRITEBACK if the victim is valid and dirty, else go to FILL.
  - WRITEBACK:
    - pmem_write=1, wb_addr_sel=1, busy=1.
    - Hold until pmem_resp, then go to FILL.
  - FILL:
    - pmem_read=1, wb_addr_sel=0, busy=1.
    - On pmem_resp: way_load=victim_way for exactly that one cycle (combinational with pmem_resp), and touch the PLRU of the latched set with the victim. Next state is IDLE.
- Busy timing: busy drops in the IDLE cycle that follows. The CPU's re-presented access then hits, with no extra PLRU touch beyond the normal hit touch.
- Latency:
  - Clean miss: 1 cycle + fill response time.
  - Dirty miss: 1 cycle + writeback response time + fill response time.
  - Hits: no added cycles.
- Boundary conditions:
  - pmem_resp seen in IDLE is ignored.
  - req dropping mid-miss does not abort; the miss completes.
  - set_index, valid and dirty are ignored outside IDLE (latched values are used).
  - pmem_read and pmem_write are never high together.
  - way_load is never asserted outside FILL & pmem_resp.
- PLRU storage uses NUM_SETS×3 flops. A set's tree changes only on a hit touch or a fill touch of that set.

Test Plan:
- Reset, then req=1, set=2, hit=0, valid=4'b1111, dirty=0 → victim_way=4'b0001, state FILL, pmem_read=1. Resp after 3 cycles → way_load=4'b0001 in that cycle; set 2 PLRU=3'b011; busy=0 next cycle.
- Set 5 with valid=4'b1011, clean miss → victim_way=4'b0100 (lowest invalid way), PLRU not consulted. After fill, set 5 PLRU b0=0, b2=1.
- Dirty miss: set 1, valid=4'b1111, dirty=4'b0001, PLRU=000 → pmem_write=1, wb_addr_sel=1 until resp, then pmem_read=1, wb_addr_sel=0. way_load=4'b0001 only on the second resp; pmem_read and pmem_write never overlap.
- Hit sequence on set 0: ways 0,1,2,3 each hit once → PLRU goes 011 → 001 → 100 → 000. A following full-set miss picks victim 4'b0001.
- rst asserted during WRITEBACK → next cycle pmem_write=0, busy=0, no way_load. A fresh miss after reset behaves as from IDLE with all PLRU=000.
- pmem_resp pulsed while IDLE with req=0 → no state change, no PLRU change, all outputs remain 0.
